sobel_window_kernel: RTL and testbench

Downstream consumer of the 16-cell line-buffer FIFO chain in the Sobel datapath. Takes three vertically aligned pixel taps per accepted pixel and builds a 3x3 sliding window. Computes the Sobel Gx/Gy gradients through a 2-stage pipeline and emits a saturated 8-bit magnitude plus a thresholded edge bit for every interior pixel. Tracks column and row position so border windows are suppressed and frame boundaries are flagged.

---
 rtl/sobel_window_kernel_pkg.sv | 18 +
 rtl/sobel_window_kernel_if.sv | 24 ++
 rtl/sobel_gradient_pipe.sv | 71 +++++++
 rtl/sobel_window_kernel.sv | 92 +++++++++
 tb/tb_sobel_window_kernel.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_window_kernel_pkg.sv
// rtl/sobel_window_kernel_pkg.sv - shared widths, types and helpers for the Sobel window kernel
package sobel_pkg;

    localparam int PIX_W   = 8;
    localparam int GRAD_W  = 11;
    localparam int MAG_W   = 11;
    localparam int MAG_MAX = 255;

    typedef logic        [PIX_W-1:0]  pixel_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic        [MAG_W-1:0]  mag_t;

    // Zero-extend an unsigned pixel into the signed gradient domain
    function automatic grad_t widen(input pixel_t p);
        return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

endpackage

// File: rtl/sobel_window_kernel_if.sv
// rtl/sobel_window_kernel_if.sv - pixel taps in, magnitude/edge results out
interface sobel_window_kernel_if;
    import sobel_pkg::*;

    logic   Enable;
    pixel_t Row0In;
    pixel_t Row1In;
    pixel_t Row2In;
    pixel_t Threshold;
    pixel_t MagOut;
    logic   EdgeOut;
    logic   ValidOut;
    logic   FrameDone;

    modport master (
        output Enable, Row0In, Row1In, Row2In, Threshold,
        input  MagOut, EdgeOut, ValidOut, FrameDone
    );

    modport slave (
        input  Enable, Row0In, Row1In, Row2In, Threshold,
        output MagOut, EdgeOut, ValidOut, FrameDone
    );
endinterface

// File: rtl/sobel_gradient_pipe.sv
// rtl/sobel_gradient_pipe.sv - two-stage Sobel gradient, magnitude, saturation and threshold
module sobel_gradient_pipe
    import sobel_pkg::*;
(
    input  logic   CLK,
    input  logic   Reset_n,
    input  pixel_t w00, w01, w02,
    input  pixel_t w10, w11, w12,
    input  pixel_t w20, w21, w22,
    input  logic   valid_in,
    input  pixel_t threshold,
    output pixel_t mag_out,
    output logic   edge_out,
    output logic   valid_out
);

    grad_t gx_c, gy_c;
    grad_t gx_q, gy_q;
    logic  v1_q;
    mag_t  abs_x, abs_y, mag_sum;
    pixel_t mag_sat;

    // Centre pixel has zero weight in both kernels
    logic unused_centre;
    assign unused_centre = ^w11;

    // Right minus left columns, bottom minus top rows
    always_comb begin
        gx_c = (widen(w02) + (widen(w12) <<< 1) + widen(w22))
             - (widen(w00) + (widen(w10) <<< 1) + widen(w20));
        gy_c = (widen(w20) + (widen(w21) <<< 1) + widen(w22))
             - (widen(w00) + (widen(w01) <<< 1) + widen(w02));
    end

    // Stage 1: register gradients; the valid bit moves every cycle so bubbles flow through
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            gx_q <= '0;
            gy_q <= '0;
            v1_q <= 1'b0;
        end else begin
            gx_q <= gx_c;
            gy_q <= gy_c;
            v1_q <= valid_in;
        end
    end

    // L1 magnitude fits MAG_W unsigned (max 2040), then clamps to a pixel
    always_comb begin
        abs_x   = gx_q[GRAD_W-1] ? mag_t'(-gx_q) : mag_t'(gx_q);
        abs_y   = gy_q[GRAD_W-1] ? mag_t'(-gy_q) : mag_t'(gy_q);
        mag_sum = abs_x + abs_y;
        mag_sat = (mag_sum > mag_t'(MAG_MAX)) ? pixel_t'(MAG_MAX) : mag_sum[PIX_W-1:0];
    end

    // Stage 2: results update only on valid so they hold across bubbles
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            mag_out   <= '0;
            edge_out  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= v1_q;
            if (v1_q) begin
                mag_out  <= mag_sat;
                edge_out <= (mag_sat >= threshold);
            end
        end
    end

endmodule

// File: rtl/sobel_window_kernel.sv
// rtl/sobel_window_kernel.sv - 3x3 window, raster counters and frame pulse around the gradient pipe
module sobel_window_kernel
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input logic CLK,
    input logic Reset_n,
    sobel_window_kernel_if.slave bus
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic PHASE_PRIME  = 1'b0;
    localparam logic PHASE_STREAM = 1'b1;

    pixel_t           win [3][3];
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             phase;
    logic             last_col, last_row;
    logic             win_valid;
    logic             last_accept;

    // The first two lines only prime the window, so stale taps never reach the output
    always_comb begin
        phase    = (row >= ROW_W'(2)) ? PHASE_STREAM : PHASE_PRIME;
        last_col = (col == COL_W'(IMG_WIDTH - 1));
        last_row = (row == ROW_W'(IMG_HEIGHT - 1));
    end

    // Shift every row left on accept, new taps enter the right column
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else if (bus.Enable) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= bus.Row0In;
            win[1][2] <= bus.Row1In;
            win[2][2] <= bus.Row2In;
        end
    end

    // Raster position of the accepted sample; column first, wrap at frame end
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            col <= '0;
            row <= '0;
        end else if (bus.Enable) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Window qualifier plus a two-step frame pulse aligned with the gradient stage
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            win_valid     <= 1'b0;
            last_accept   <= 1'b0;
            bus.FrameDone <= 1'b0;
        end else begin
            win_valid     <= bus.Enable && (phase == PHASE_STREAM) && (col >= COL_W'(2));
            last_accept   <= bus.Enable && last_col && last_row;
            bus.FrameDone <= last_accept;
        end
    end

    sobel_gradient_pipe u_pipe (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .w00       (win[0][0]), .w01 (win[0][1]), .w02 (win[0][2]),
        .w10       (win[1][0]), .w11 (win[1][1]), .w12 (win[1][2]),
        .w20       (win[2][0]), .w21 (win[2][1]), .w22 (win[2][2]),
        .valid_in  (win_valid),
        .threshold (bus.Threshold),
        .mag_out   (bus.MagOut),
        .edge_out  (bus.EdgeOut),
        .valid_out (bus.ValidOut)
    );

endmodule

// File: tb/tb_sobel_window_kernel.sv
// tb/tb_sobel_window_kernel.sv - randomized self-checking bench against an image-level Sobel model
`timescale 1ns/1ps
module tb_sobel_window_kernel;

    localparam int W = 16;
    localparam int H = 16;
    localparam int N_OUT = (W - 2) * (H - 2);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sobel_window_kernel_if bus();

    sobel_window_kernel #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    int img [H][W];
    int thr;

    int     exp_mag[$];
    int     exp_edge[$];
    longint exp_t[$];
    longint exp_fd[$];
    int     obs_mag[$];
    int     obs_edge[$];
    longint obs_t[$];
    longint obs_fd[$];

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.ValidOut) begin
            obs_mag.push_back(int'(bus.MagOut));
            obs_edge.push_back(int'(bus.EdgeOut));
            obs_t.push_back(longint'($time));
        end
        if (bus.FrameDone)
            obs_fd.push_back(longint'($time));
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached before summary");
        $fatal(1, "timeout");
    end

    // Sobel L1 magnitude at image centre (r,c), clamped to 255
    function automatic int ref_mag(input int r, input int c);
        int gx, gy, m;
        gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    task automatic clear_queues();
        #1;
        exp_mag.delete(); exp_edge.delete(); exp_t.delete(); exp_fd.delete();
        obs_mag.delete(); obs_edge.delete(); obs_t.delete(); obs_fd.delete();
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
    endtask

    // Plays the line buffers: mode 0 continuous, 1 three on/three off, 2 random gaps
    task automatic drive_frame(input int mode, input int stop_r, input int stop_c);
        int  gc;
        bit  on;
        int  m;
        bit  stop;
        gc   = 0;
        stop = 1'b0;
        bus.Threshold = 8'(thr);
        for (int r = 0; r < H && !stop; r++) begin
            for (int c = 0; c < W && !stop; c++) begin
                while (1) begin
                    if (mode == 0)      on = 1'b1;
                    else if (mode == 1) on = ((gc / 3) % 2) == 0;
                    else                on = ($urandom_range(3) != 0);
                    if (on) break;
                    @(negedge clk);
                    bus.Enable = 1'b0;
                    bus.Row0In = 8'($urandom); bus.Row1In = 8'($urandom); bus.Row2In = 8'($urandom);
                    gc++;
                end
                @(negedge clk);
                bus.Enable = 1'b1;
                bus.Row0In = (r >= 2) ? 8'(img[r-2][c]) : 8'($urandom);
                bus.Row1In = (r >= 1) ? 8'(img[r-1][c]) : 8'($urandom);
                bus.Row2In = 8'(img[r][c]);
                if (r >= 2 && c >= 2) begin
                    m = ref_mag(r - 1, c - 1);
                    exp_mag.push_back(m);
                    exp_edge.push_back((m >= thr) ? 1 : 0);
                    exp_t.push_back(longint'($time) + 30);
                end
                if (r == H - 1 && c == W - 1)
                    exp_fd.push_back(longint'($time) + 20);
                gc++;
                if (r == stop_r && c == stop_c) stop = 1'b1;
            end
        end
        @(negedge clk);
        bus.Enable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Enable = 1'b0; bus.Row0In = '0; bus.Row1In = '0; bus.Row2In = '0; bus.Threshold = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.ValidOut !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", bus.ValidOut); end
        checks++; if (bus.MagOut !== 8'd0) begin failures++; $display("FAIL reset_mag got=%0d want=0", bus.MagOut); end
        checks++; if (bus.EdgeOut !== 1'b0) begin failures++; $display("FAIL reset_edge got=%0b want=0", bus.EdgeOut); end
        checks++; if (bus.FrameDone !== 1'b0) begin failures++; $display("FAIL reset_framedone got=%0b want=0", bus.FrameDone); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_constant_image();
        for (int k = 0; k < 2; k++) begin
            thr = (k == 0) ? 1 : 0;
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 50;
            clear_queues();
            drive_frame(0, -1, -1);
            drain();
            checks++; if (obs_mag.size() != N_OUT) begin failures++; $display("FAIL const_count thr=%0d got=%0d want=%0d", thr, obs_mag.size(), N_OUT); end
            for (int i = 0; i < exp_mag.size() && i < obs_mag.size(); i++) begin
                checks++;
                if (obs_mag[i] !== exp_mag[i] || obs_edge[i] !== exp_edge[i] || obs_t[i] !== exp_t[i]) begin
                    failures++;
                    $display("FAIL const_out thr=%0d [%0d] mag=%0d edge=%0d t=%0d want mag=%0d edge=%0d t=%0d",
                             thr, i, obs_mag[i], obs_edge[i], obs_t[i], exp_mag[i], exp_edge[i], exp_t[i]);
                end
            end
            checks++; if (obs_fd.size() != 1 || obs_fd[0] != exp_fd[0]) begin failures++; $display("FAIL const_framedone pulses=%0d want 1 at t=%0d", obs_fd.size(), exp_fd[0]); end
        end
    endtask

    task automatic test_vertical_step();
        thr = 128;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 8) ? 100 : 0;
        clear_queues();
        drive_frame(0, -1, -1);
        drain();
        checks++; if (obs_mag.size() != N_OUT) begin failures++; $display("FAIL step_count got=%0d want=%0d", obs_mag.size(), N_OUT); end
        for (int i = 0; i < exp_mag.size() && i < obs_mag.size(); i++) begin
            checks++;
            if (obs_mag[i] !== exp_mag[i] || obs_edge[i] !== exp_edge[i] || obs_t[i] !== exp_t[i]) begin
                failures++;
                $display("FAIL step_out [%0d] mag=%0d edge=%0d t=%0d want mag=%0d edge=%0d t=%0d",
                         i, obs_mag[i], obs_edge[i], obs_t[i], exp_mag[i], exp_edge[i], exp_t[i]);
            end
        end
        checks++; if (obs_fd.size() != 1 || obs_fd[0] != exp_fd[0]) begin failures++; $display("FAIL step_framedone pulses=%0d want 1", obs_fd.size()); end
    endtask

    task automatic test_ramp_threshold();
        for (int k = 0; k < 2; k++) begin
            thr = 80 + k;
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 10 * c;
            clear_queues();
            drive_frame(0, -1, -1);
            drain();
            checks++; if (obs_mag.size() != N_OUT) begin failures++; $display("FAIL ramp_count thr=%0d got=%0d want=%0d", thr, obs_mag.size(), N_OUT); end
            for (int i = 0; i < obs_mag.size(); i++) begin
                checks++;
                if (obs_mag[i] !== 80 || obs_edge[i] !== ((thr == 80) ? 1 : 0)) begin
                    failures++;
                    $display("FAIL ramp_out thr=%0d [%0d] mag=%0d edge=%0d want mag=80 edge=%0d",
                             thr, i, obs_mag[i], obs_edge[i], (thr == 80) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_back_to_back_and_gaps();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(255));
        thr = int'($urandom_range(40, 200));
        for (int mode = 0; mode < 3; mode++) begin
            clear_queues();
            drive_frame(mode, -1, -1);
            drain();
            checks++; if (obs_mag.size() != N_OUT) begin failures++; $display("FAIL gaps_count mode=%0d got=%0d want=%0d", mode, obs_mag.size(), N_OUT); end
            for (int i = 0; i < exp_mag.size() && i < obs_mag.size(); i++) begin
                checks++;
                if (obs_mag[i] !== exp_mag[i] || obs_edge[i] !== exp_edge[i] || obs_t[i] !== exp_t[i]) begin
                    failures++;
                    $display("FAIL gaps_out mode=%0d [%0d] mag=%0d edge=%0d t=%0d want mag=%0d edge=%0d t=%0d",
                             mode, i, obs_mag[i], obs_edge[i], obs_t[i], exp_mag[i], exp_edge[i], exp_t[i]);
                end
            end
            checks++; if (obs_fd.size() != 1 || obs_fd[0] != exp_fd[0]) begin failures++; $display("FAIL gaps_framedone mode=%0d pulses=%0d want 1", mode, obs_fd.size()); end
        end
    endtask

    task automatic test_mid_frame_reset();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(255));
        thr = 100;
        clear_queues();
        drive_frame(0, 5, 9);
        clear_queues();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ValidOut !== 1'b0 || bus.MagOut !== 8'd0 || bus.EdgeOut !== 1'b0 || bus.FrameDone !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs valid=%0b mag=%0d edge=%0b fd=%0b want all 0",
                     bus.ValidOut, bus.MagOut, bus.EdgeOut, bus.FrameDone);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drain();
        checks++; if (obs_mag.size() != 0 || obs_fd.size() != 0) begin failures++; $display("FAIL midreset_flush valids=%0d fd=%0d want 0", obs_mag.size(), obs_fd.size()); end
        clear_queues();
        drive_frame(0, -1, -1);
        drain();
        checks++; if (obs_mag.size() != N_OUT) begin failures++; $display("FAIL midreset_count got=%0d want=%0d", obs_mag.size(), N_OUT); end
        for (int i = 0; i < exp_mag.size() && i < obs_mag.size(); i++) begin
            checks++;
            if (obs_mag[i] !== exp_mag[i] || obs_edge[i] !== exp_edge[i] || obs_t[i] !== exp_t[i]) begin
                failures++;
                $display("FAIL midreset_out [%0d] mag=%0d edge=%0d t=%0d want mag=%0d edge=%0d t=%0d",
                         i, obs_mag[i], obs_edge[i], obs_t[i], exp_mag[i], exp_edge[i], exp_t[i]);
            end
        end
        checks++; if (obs_fd.size() != 1 || obs_fd[0] != exp_fd[0]) begin failures++; $display("FAIL midreset_framedone pulses=%0d want 1", obs_fd.size()); end
    endtask

    initial begin
        test_reset();
        test_constant_image();
        test_vertical_step();
        test_ramp_threshold();
        test_back_to_back_and_gaps();
        test_mid_frame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
